arb_req_queue: RTL and testbench

ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

---
 rtl/arb_req_queue.sv | 131 +++++++++++++
 tb/tb_arb_req_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_queue.sv
// Per-source pending request counters feeding a downstream priority arbiter.
// Define ARB_STARVE_DET_EN to build the per-source starvation detectors.
module arb_req_queue #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic       arb_clk,
   input  logic       arb_rst_n,
   input  logic [3:0] src_push,
   output logic [3:0] src_full,
   output logic       arb_req0,
   output logic       arb_req1,
   output logic       arb_req2,
   output logic       arb_req3,
   input  logic       arb_gnt0,
   input  logic       arb_gnt1,
   input  logic       arb_gnt2,
   input  logic       arb_gnt3,
   output logic       pend_empty,
   output logic [3:0] ovf_err,
   output logic [3:0] gnt_err,
   output logic [3:0] starve
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DMAX = CW'(DEPTH);
   localparam logic [CW-1:0] ONE  = CW'(1);

   if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
      $error("arb_req_queue: DEPTH out of range");
   end
   if (STARVE_LIMIT < 2 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("arb_req_queue: STARVE_LIMIT out of range");
   end

   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [3:0]    ovf_q, ovf_d;
   logic [3:0]    gerr_q, gerr_d;
   logic [3:0]    gnt;
   logic [3:0]    req;

   assign gnt = {arb_gnt3, arb_gnt2, arb_gnt1, arb_gnt0};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i]  = cnt_q[i];
         ovf_d[i]  = ovf_q[i];
         gerr_d[i] = gerr_q[i];
         case ({src_push[i], gnt[i]})
            2'b10: begin
               if (cnt_q[i] == DMAX) ovf_d[i] = 1'b1;
               else cnt_d[i] = cnt_q[i] + ONE;
            end
            2'b01: begin
               if (cnt_q[i] == '0) gerr_d[i] = 1'b1;
               else cnt_d[i] = cnt_q[i] - ONE;
            end
            2'b11: begin
               // the grant can only cancel a request that already existed
               if (cnt_q[i] == '0) begin
                  cnt_d[i]  = ONE;
                  gerr_d[i] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req[i] = (cnt_q[i] > ONE) ||
                  ((cnt_q[i] == ONE) && !gnt[i]);
         src_full[i] = (cnt_q[i] == DMAX);
      end
      pend_empty = (cnt_q[0] == '0) && (cnt_q[1] == '0) &&
                   (cnt_q[2] == '0) && (cnt_q[3] == '0);
   end

   assign arb_req0 = req[0];
   assign arb_req1 = req[1];
   assign arb_req2 = req[2];
   assign arb_req3 = req[3];
   assign ovf_err  = ovf_q;
   assign gnt_err  = gerr_q;

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         ovf_q  <= '0;
         gerr_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         ovf_q  <= ovf_d;
         gerr_q <= gerr_d;
      end
   end

`ifdef ARB_STARVE_DET_EN
   logic [7:0] wait_q [4];
   logic [7:0] wait_d [4];
   logic [3:0] stv_q, stv_d;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (gnt[i] || (cnt_q[i] == '0)) wait_d[i] = '0;
         else if (req[i] && (wait_q[i] != 8'hFF))
            wait_d[i] = wait_q[i] + 8'd1;
         else wait_d[i] = wait_q[i];
         stv_d[i] = stv_q[i] ||
                    (wait_d[i] >= 8'(STARVE_LIMIT));
      end
   end

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         for (int i = 0; i < 4; i++) wait_q[i] <= '0;
         stv_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) wait_q[i] <= wait_d[i];
         stv_q <= stv_d;
      end
   end

   assign starve = stv_q;
`else
   assign starve = 4'b0000;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue with a registered fixed-priority
// arbiter model and a grant-order scoreboard.
module tb_arb_req_queue;

   logic       arb_clk = 1'b0;
   logic       arb_rst_n;
   logic [3:0] src_push;
   logic [3:0] src_full;
   logic       arb_req0, arb_req1, arb_req2, arb_req3;
   logic       pend_empty;
   logic [3:0] ovf_err, gnt_err, starve;
   logic [3:0] g_q, man_g, req;
   bit         arb_en;
   int         vecs, errs, gcount;
   int         sb[$];

   always #5 arb_clk = ~arb_clk;

   arb_req_queue dut (
      .arb_clk    (arb_clk),
      .arb_rst_n  (arb_rst_n),
      .src_push   (src_push),
      .src_full   (src_full),
      .arb_req0   (arb_req0),
      .arb_req1   (arb_req1),
      .arb_req2   (arb_req2),
      .arb_req3   (arb_req3),
      .arb_gnt0   (g_q[0]),
      .arb_gnt1   (g_q[1]),
      .arb_gnt2   (g_q[2]),
      .arb_gnt3   (g_q[3]),
      .pend_empty (pend_empty),
      .ovf_err    (ovf_err),
      .gnt_err    (gnt_err),
      .starve     (starve)
   );

   assign req = {arb_req3, arb_req2, arb_req1, arb_req0};

   function automatic logic [3:0] pick(input logic [3:0] r);
      for (int i = 0; i < 4; i++)
         if (r[i]) return 4'(1 << i);
      return 4'b0000;
   endfunction

   function automatic int idx(input logic [3:0] g);
      for (int i = 0; i < 4; i++)
         if (g[i]) return i;
      return -1;
   endfunction

   always @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) g_q <= 4'b0000;
      else if (arb_en) g_q <= pick(req);
      else g_q <= man_g;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge arb_clk) begin
      if (arb_en && arb_rst_n && (|g_q)) begin
         gcount++;
         if (sb.size() == 0) chk("unexpected_gnt", 32'(g_q), 32'h0);
         else chk("gnt_order", 32'(idx(g_q)), 32'(sb.pop_front()));
      end
   end

   task automatic step();
      @(posedge arb_clk);
      #1;
   endtask

   task automatic drain(input string tag, input int maxc);
      int n = 0;
      while (!(pend_empty && sb.size() == 0 && g_q == 4'b0) &&
             n < maxc) begin
         step();
         n++;
      end
      chk(tag, 32'(n < maxc), 32'h1);
   endtask

   initial begin
      vecs = 0; errs = 0; gcount = 0;
      arb_en = 0; man_g = 4'b0; src_push = 4'b0;
      arb_rst_n = 1'b0;
      #1;
      chk("rst_req", 32'(req), 32'h0);
      chk("rst_empty", 32'(pend_empty), 32'h1);
      chk("rst_full", 32'(src_full), 32'h0);
      chk("rst_errs", {20'h0, ovf_err, gnt_err, starve}, 32'h0);
      step(); step();
      arb_rst_n = 1'b1;
      repeat (5) step();
      chk("idle_req", 32'(req), 32'h0);
      chk("idle_empty", 32'(pend_empty), 32'h1);
      chk("idle_errs", {20'h0, ovf_err, gnt_err, starve}, 32'h0);

      // single push on source 2 with the arbiter attached
      arb_en = 1; gcount = 0;
      sb.push_back(2);
      src_push = 4'b0100;
      step();
      src_push = 4'b0;
      chk("push2_req", 32'(req), 32'h4);
      drain("push2_drain", 10);
      chk("push2_gcount", 32'(gcount), 32'h1);
      chk("push2_cnt", 32'(dut.cnt_q[2]), 32'h0);
      chk("push2_gerr", 32'(gnt_err), 32'h0);

      // overfill source 0 without grants
      arb_en = 0; man_g = 4'b0;
      for (int k = 1; k <= 5; k++) begin
         src_push = 4'b0001;
         step();
         if (k == 3) chk("fill3_full", 32'(src_full), 32'h0);
         if (k == 4) begin
            chk("fill4_full", 32'(src_full), 32'h1);
            chk("fill4_ovf", 32'(ovf_err), 32'h0);
         end
         if (k == 5) begin
            chk("fill5_ovf", 32'(ovf_err), 32'h1);
            chk("fill5_cnt", 32'(dut.cnt_q[0]), 32'h4);
         end
      end

      // reset mid-operation, traffic ignored while low
      arb_rst_n = 1'b0;
      src_push = 4'b1111;
      #1;
      chk("mid_rst_empty", 32'(pend_empty), 32'h1);
      chk("mid_rst_ovf", 32'(ovf_err), 32'h0);
      step(); step();
      chk("mid_rst_hold", 32'(pend_empty), 32'h1);
      arb_rst_n = 1'b1;
      src_push = 4'b0001;
      sb.push_back(0);
      arb_en = 1;
      step();
      src_push = 4'b0;
      chk("first_push_cnt", 32'(dut.cnt_q[0]), 32'h1);
      drain("first_push_drain", 10);

      // two pushes each on sources 1 and 3
      gcount = 0;
      sb.push_back(1); sb.push_back(1);
      sb.push_back(3); sb.push_back(3);
      src_push = 4'b1010;
      step(); step();
      src_push = 4'b0;
      drain("order_drain", 20);
      chk("order_gcount", 32'(gcount), 32'h4);
      chk("order_empty", 32'(pend_empty), 32'h1);
      chk("order_gerr", 32'(gnt_err), 32'h0);

      // forced grant on an empty source
      arb_en = 0;
      man_g = 4'b0010;
      step();
      man_g = 4'b0;
      step();
      chk("gerr_bit", 32'(gnt_err), 32'h2);
      chk("gerr_cnt", 32'(dut.cnt_q[1]), 32'h0);
      src_push = 4'b0010;
      step(); step();
      src_push = 4'b0;
      man_g = 4'b0010;
      step();
      src_push = 4'b0010; man_g = 4'b0;
      step();
      src_push = 4'b0;
      chk("pg_cnt2", 32'(dut.cnt_q[1]), 32'h2);
      chk("pg_gerr", 32'(gnt_err), 32'h2);

      // push and grant together on a full source
      src_push = 4'b0100;
      repeat (4) step();
      src_push = 4'b0;
      man_g = 4'b0100;
      step();
      src_push = 4'b0100; man_g = 4'b0;
      step();
      src_push = 4'b0;
      chk("pg_full_cnt", 32'(dut.cnt_q[2]), 32'h4);
      chk("pg_full_ovf", 32'(ovf_err), 32'h0);
      chk("pg_full_flag", 32'(src_full[2]), 32'h1);

      // source 0 waits while source 1 is serviced every cycle
      arb_rst_n = 1'b0;
      #1;
      step();
      arb_rst_n = 1'b1;
      src_push = 4'b0001;
      step();
      src_push = 4'b0010; man_g = 4'b0010;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 10) chk("starve_early", 32'(starve), 32'h0);
      end
      src_push = 4'b0; man_g = 4'b0;
`ifdef ARB_STARVE_DET_EN
      chk("starve_late", 32'(starve), 32'h1);
`else
      chk("starve_late", 32'(starve), 32'h0);
`endif
      chk("starve_gerr", 32'(gnt_err), 32'h0);
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
